// File: rtl/i2c_pkg.sv
// i2c_pkg: shared types and default constants for the I2C target byte transmitter.
// Holds the FSM state encoding and the data-hold defaults.
package i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_LOW,
    HOLD,
    DATA,
    HIGH,
    ACK,
    ACK_END
  } state_t;

  localparam int HOLD_SHORT_DEF = 8;
  localparam int HOLD_LONG_DEF  = 16;
  localparam int CNT_W_DEF      = 5;

endpackage

// File: rtl/i2c_sync_edge.sv
// i2c_sync_edge: 2-FF synchroniser bank, reset to 1 (idle bus level).
// Rise/fall pulses are produced for bit 0 only; other bits are level-only.
module i2c_sync_edge #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic         rise,
  output logic         fall
);

  logic [W-1:0] s1;
  logic [W-1:0] s2;
  logic         s3;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '1;
      s2 <= '1;
      s3 <= 1'b1;
    end else begin
      s1 <= d;
      s2 <= s1;
      s3 <= s2[0];
    end
  end

  assign q    = s2;
  assign rise = s2[0] & ~s3;
  assign fall = ~s2[0] & s3;

endmodule

// File: rtl/i2c_tgt_byte_tx.sv
// i2c_tgt_byte_tx: target-side I2C byte transmitter.
// Shifts a byte MSB-first onto SDA with a programmable hold after SCL falls.
module i2c_tgt_byte_tx
  import i2c_pkg::*;
#(
  parameter int HOLD_SHORT = HOLD_SHORT_DEF,
  parameter int HOLD_LONG  = HOLD_LONG_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic       CLK,
  input  logic       RB,
  input  logic       SCL_F,
  input  logic       SDA_F,
  input  logic       DS,
  input  logic       BYP,
  input  logic       ABORT,
  input  logic [7:0] TX_DATA,
  input  logic       TX_VLD,
  output logic       TX_RDY,
  output logic       SDA_OE,
  output logic       ACK_N,
  output logic       ACK_VLD
);

  logic [1:0] sync_q;
  logic       scl_s;
  logic       sda_s;
  logic       scl_rise;
  logic       scl_fall;

  i2c_sync_edge #(.W(2)) u_sync (
    .clk  (CLK),
    .rst_n(RB),
    .d    ({SDA_F, SCL_F}),
    .q    (sync_q),
    .rise (scl_rise),
    .fall (scl_fall)
  );

  assign scl_s = sync_q[0];
  assign sda_s = sync_q[1];

  state_t           state, state_n;
  logic [7:0]       shreg, shreg_n;
  logic [2:0]       bitcnt, bitcnt_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hold, hold_n;
  logic [CNT_W-1:0] hold_sel;
  logic             hold_done;
  logic             ack_slot, ack_slot_n;
  logic             oe, oe_n;
  logic             ack_n, ack_n_n;
  logic             ack_vld, ack_vld_n;

  assign hold_sel  = BYP ? '0 :
                     (DS ? CNT_W'(HOLD_SHORT) : CNT_W'(HOLD_LONG));
  assign hold_done = (hold == '0) || (cnt == hold - CNT_W'(1));

  always_comb begin
    state_n    = state;
    shreg_n    = shreg;
    bitcnt_n   = bitcnt;
    cnt_n      = cnt;
    hold_n     = hold;
    ack_slot_n = ack_slot;
    oe_n       = oe;
    ack_n_n    = ack_n;
    ack_vld_n  = 1'b0;
    unique case (state)
      IDLE: begin
        oe_n = 1'b0;
        if (TX_VLD) begin
          shreg_n    = TX_DATA;
          bitcnt_n   = 3'd7;
          ack_slot_n = 1'b0;
          state_n    = WAIT_LOW;
        end
      end
      WAIT_LOW: begin
        if (!scl_s) begin
          cnt_n   = '0;
          hold_n  = hold_sel;
          state_n = HOLD;
        end
      end
      HOLD: begin
        cnt_n = cnt + CNT_W'(1);
        // An early SCL rise cuts the hold short rather than stalling the bit
        if (hold_done || scl_rise) begin
          oe_n = ack_slot ? 1'b0 : ~shreg[7];
          if (ack_slot && scl_rise) begin
            ack_n_n   = sda_s;
            ack_vld_n = 1'b1;
            state_n   = ACK_END;
          end else if (ack_slot) begin
            state_n = ACK;
          end else begin
            state_n = scl_rise ? HIGH : DATA;
          end
        end
      end
      DATA: begin
        if (scl_rise) state_n = HIGH;
      end
      HIGH: begin
        if (scl_fall) begin
          cnt_n   = '0;
          hold_n  = hold_sel;
          state_n = HOLD;
          if (bitcnt == 3'd0) begin
            ack_slot_n = 1'b1;
          end else begin
            shreg_n  = {shreg[6:0], 1'b0};
            bitcnt_n = bitcnt - 3'd1;
          end
        end
      end
      ACK: begin
        oe_n = 1'b0;
        if (scl_rise) begin
          ack_n_n   = sda_s;
          ack_vld_n = 1'b1;
          state_n   = ACK_END;
        end
      end
      ACK_END: begin
        if (scl_fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    if (ABORT) begin
      state_n   = IDLE;
      oe_n      = 1'b0;
      ack_n_n   = ack_n;
      ack_vld_n = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!RB) begin
      state    <= IDLE;
      shreg    <= '0;
      bitcnt   <= '0;
      cnt      <= '0;
      hold     <= '0;
      ack_slot <= 1'b0;
      oe       <= 1'b0;
      ack_n    <= 1'b1;
      ack_vld  <= 1'b0;
    end else begin
      state    <= state_n;
      shreg    <= shreg_n;
      bitcnt   <= bitcnt_n;
      cnt      <= cnt_n;
      hold     <= hold_n;
      ack_slot <= ack_slot_n;
      oe       <= oe_n;
      ack_n    <= ack_n_n;
      ack_vld  <= ack_vld_n;
    end
  end

  assign TX_RDY  = (state == IDLE);
  assign SDA_OE  = oe;
  assign ACK_N   = ack_n;
  assign ACK_VLD = ack_vld;

endmodule

// File: tb/tb_i2c_tgt_byte_tx.sv
// tb_i2c_tgt_byte_tx: directed bench with an event-schedule model of the bus timing.
// The bench plays the I2C controller and predicts each output change by cycle number.
module tb_i2c_tgt_byte_tx;

  localparam int LOWC  = 24;
  localparam int HIGHC = 20;
  localparam int K_OE  = 0;
  localparam int K_RDY = 1;
  localparam int K_ACK = 2;
  localparam int K_CLR = 3;
  localparam int K_RST = 4;

  typedef struct {
    int at;
    int kind;
    bit val;
  } ev_t;

  logic       CLK = 1'b0;
  logic       RB = 1'b0;
  logic       SCL_F = 1'b0;
  logic       SDA_F;
  logic       DS = 1'b0;
  logic       BYP = 1'b0;
  logic       ABORT = 1'b0;
  logic [7:0] TX_DATA = 8'h00;
  logic       TX_VLD = 1'b0;
  logic       TX_RDY;
  logic       SDA_OE;
  logic       ACK_N;
  logic       ACK_VLD;

  logic       ctrl_sda = 1'b1;
  ev_t        evq[$];
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;
  int         vcount = 0;
  int         chg_edge = 0;
  int         last_fall = 0;
  int         dly[9];
  int         fe[9];
  bit         exp_oe = 1'b0;
  bit         exp_rdy = 1'b1;
  bit         exp_ackn = 1'b1;
  bit         exp_vld = 1'b0;
  bit         chk_en = 1'b0;
  logic       prev_oe = 1'b0;
  logic       p1 = 1'b1;
  logic       p2 = 1'b1;
  logic       sp = 1'b1;
  logic       rst_e = 1'b1;
  logic       abt_e = 1'b0;
  int         stop_slot = -1;
  int         stop_kind = 0;
  int         ds_slot = -1;
  logic       ds_val = 1'b0;
  bit         chain_next = 1'b0;
  logic [7:0] chain_data = 8'h00;
  logic       oe_at_stop = 1'b0;

  // Open-drain bus: either side may pull SDA low
  assign SDA_F = ctrl_sda & ~SDA_OE;

  always #5 CLK = ~CLK;

  i2c_tgt_byte_tx dut (
    .CLK    (CLK),
    .RB     (RB),
    .SCL_F  (SCL_F),
    .SDA_F  (SDA_F),
    .DS     (DS),
    .BYP    (BYP),
    .ABORT  (ABORT),
    .TX_DATA(TX_DATA),
    .TX_VLD (TX_VLD),
    .TX_RDY (TX_RDY),
    .SDA_OE (SDA_OE),
    .ACK_N  (ACK_N),
    .ACK_VLD(ACK_VLD)
  );

  function automatic void check(string nm, logic act, logic want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s cyc=%0d got=%b want=%b", nm, cyc, act, want);
  endfunction

  function automatic void check_int(string nm, int act, int want);
    checks++;
    if (act == want) passes++;
    else $display("FAIL %s got=%0d want=%0d", nm, act, want);
  endfunction

  function automatic void sched(int at, int kind, bit val);
    evq.push_back(ev_t'{at, kind, val});
  endfunction

  // Cycles from hold start to SDA change: the hold count, at least one
  function automatic int hdly();
    int h;
    h = BYP ? 0 : (DS ? 8 : 16);
    return (h == 0) ? 1 : h;
  endfunction

  task automatic wait_n(input int n);
    repeat (n) @(negedge CLK);
  endtask

  always @(posedge CLK) begin
    cyc     <= cyc + 1;
    p1      <= RB ? SCL_F : 1'b1;
    p2      <= RB ? p1 : 1'b1;
    sp      <= p2;
    prev_oe <= SDA_OE;
    rst_e   <= !RB;
    abt_e   <= ABORT;
  end

  always @(posedge CLK) begin
    bit flush;
    #1;
    flush   = 1'b0;
    exp_vld = 1'b0;
    for (int i = 0; i < evq.size(); ) begin
      if (evq[i].at == cyc) begin
        case (evq[i].kind)
          K_OE:  exp_oe = evq[i].val;
          K_RDY: exp_rdy = evq[i].val;
          K_ACK: begin
            exp_ackn = evq[i].val;
            exp_vld  = 1'b1;
          end
          K_RST: begin
            flush    = 1'b1;
            exp_ackn = 1'b1;
          end
          default: flush = 1'b1;
        endcase
        evq.delete(i);
      end else begin
        i++;
      end
    end
    if (flush) begin
      exp_oe  = 1'b0;
      exp_rdy = 1'b1;
      exp_vld = 1'b0;
      evq.delete();
    end
    if (SDA_OE !== prev_oe) chg_edge = cyc;
    if (ACK_VLD === 1'b1) vcount++;
    if (chk_en) begin
      check("sda_oe", SDA_OE, exp_oe);
      check("tx_rdy", TX_RDY, exp_rdy);
      check("ack_n", ACK_N, exp_ackn);
      check("ack_vld", ACK_VLD, exp_vld);
      if (!rst_e && !abt_e) begin
        checks++;
        assert (SDA_OE === prev_oe || sp !== 1'b1) passes++;
        else $display("FAIL oe_while_scl_high cyc=%0d got=%b want=%b",
                      cyc, SDA_OE, prev_oe);
      end
    end
  end

  task automatic do_byte(input logic [7:0] d, input logic ack, input bit chained);
    int a;
    int e;
    logic v;
    if (!chained) begin
      @(negedge CLK);
      TX_DATA = d;
      TX_VLD  = 1'b1;
      a       = cyc + 1;
    end else begin
      a = last_fall + 4;
    end
    sched(a, K_RDY, 1'b0);
    sched(a + 1 + hdly(), K_OE, ~d[7]);
    while (cyc < a) @(negedge CLK);
    TX_VLD = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k == 8) ctrl_sda = ack;
      if (k == stop_slot) begin
        wait_n(LOWC - 2);
        oe_at_stop = SDA_OE;
        e = cyc;
        if (stop_kind == 1) begin
          ABORT   = 1'b1;
          TX_VLD  = 1'b1;
          TX_DATA = 8'h3C;
          sched(e + 1, K_CLR, 1'b0);
        end else begin
          RB = 1'b0;
          sched(e + 1, K_RST, 1'b0);
        end
        wait_n(1);
        ABORT    = 1'b0;
        TX_VLD   = 1'b0;
        RB       = 1'b1;
        ctrl_sda = 1'b1;
        return;
      end
      wait_n(LOWC);
      dly[k] = (k == 0) ? chg_edge - a : chg_edge - fe[k] - 3;
      SCL_F = 1'b1;
      e = cyc;
      if (k == 8) sched(e + 3, K_ACK, ack);
      if (k == ds_slot) DS = ds_val;
      wait_n(HIGHC);
      SCL_F = 1'b0;
      e = cyc;
      last_fall = e;
      if (k < 8) begin
        fe[k+1] = e;
        v = 1'b0;
        if (k < 7) v = ~d[6-k];
        sched(e + 3 + hdly(), K_OE, v);
      end else begin
        sched(e + 3, K_RDY, 1'b1);
        ctrl_sda = 1'b1;
        if (chain_next) begin
          TX_DATA = chain_data;
          TX_VLD  = 1'b1;
        end
      end
    end
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    RB     = 1'b1;
    chk_en = 1'b1;
    check("rst_sda_oe", SDA_OE, 1'b0);
    check("rst_tx_rdy", TX_RDY, 1'b1);
    check("rst_ack_n", ACK_N, 1'b1);
    check("rst_ack_vld", ACK_VLD, 1'b0);
    wait_n(4);

    vcount = 0;
    do_byte(8'hA5, 1'b0, 1'b0);
    wait_n(6);
    check("a5_ack_n", ACK_N, 1'b0);
    check("a5_tx_rdy", TX_RDY, 1'b1);
    check_int("a5_vld_pulses", vcount, 1);

    stop_slot = 4;
    stop_kind = 2;
    do_byte(8'h5A, 1'b0, 1'b0);
    stop_slot = -1;
    check("rb_ack_n", ACK_N, 1'b1);
    check("rb_sda_oe", SDA_OE, 1'b0);
    check("rb_tx_rdy", TX_RDY, 1'b1);
    wait_n(6);
    vcount = 0;
    do_byte(8'hC3, 1'b0, 1'b0);
    wait_n(6);
    check("post_rb_ack_n", ACK_N, 1'b0);
    check_int("post_rb_vld_pulses", vcount, 1);

    DS      = 1'b1;
    ds_slot = 3;
    ds_val  = 1'b0;
    do_byte(8'h55, 1'b0, 1'b0);
    ds_slot = -1;
    wait_n(6);
    check_int("ds1_accept_dly", dly[0], 9);
    check_int("ds1_dly_bit1", dly[1], 8);
    check_int("ds1_dly_bit3", dly[3], 8);
    check_int("ds0_dly_bit4", dly[4], 16);
    BYP = 1'b1;
    do_byte(8'h55, 1'b0, 1'b0);
    BYP = 1'b0;
    wait_n(6);
    check_int("byp_dly_bit1", dly[1], 1);
    check_int("byp_dly_bit6", dly[6], 1);

    vcount = 0;
    do_byte(8'h3C, 1'b1, 1'b0);
    wait_n(6);
    check("nack_ack_n", ACK_N, 1'b1);
    check_int("nack_vld_pulses", vcount, 1);

    vcount    = 0;
    stop_slot = 3;
    stop_kind = 1;
    do_byte(8'hA5, 1'b0, 1'b0);
    stop_slot = -1;
    check("abort_pre_oe", oe_at_stop, 1'b1);
    check("abort_sda_oe", SDA_OE, 1'b0);
    check("abort_tx_rdy", TX_RDY, 1'b1);
    wait_n(10);
    check_int("abort_vld_pulses", vcount, 0);
    check("abort_still_idle", TX_RDY, 1'b1);

    vcount     = 0;
    chain_next = 1'b1;
    chain_data = 8'hFF;
    do_byte(8'h00, 1'b0, 1'b0);
    chain_next = 1'b0;
    do_byte(8'hFF, 1'b0, 1'b1);
    wait_n(6);
    check_int("b2b_vld_pulses", vcount, 2);
    check("b2b_ack_n", ACK_N, 1'b0);
    check("b2b_tx_rdy", TX_RDY, 1'b1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
